apple_rand_gen: RTL and testbench

APPLE_RAND_GEN -- requirements
Module: apple_rand_gen

---
 rtl/apple_rand_gen_pkg.sv | 36 +++
 rtl/apple_rand_gen_if.sv | 42 ++++
 rtl/apple_rand_gen_lfsr16_step.sv | 18 +
 rtl/apple_rand_gen.sv | 167 ++++++++++++++++
 tb/tb_apple_rand_gen.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apple_rand_gen_pkg.sv
// Shared constants and types for the apple placement logic of the snake game.
// Holds the generator FSM states, the fallback apple location and the LFSR
// tap mask, plus the playfield bounds test used by the candidate checker.
package apple_rand_gen_pkg;

    // Shared game constant, also read by the score and placer blocks.
    localparam logic [7:0] APPLE_LUCK = 8'd7;

    // Location {y, x} shown when no in-bounds candidate could be found.
    localparam logic [7:0] DEFAULT_APPLE = 8'h46;

    // Galois feedback mask for the 16-bit maximal-length LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2
    } apple_state_t;

    // True when the candidate {y, x} lies strictly inside the playfield bounds.
    function automatic logic in_bounds(
        input logic [7:0] cand,
        input logic [3:0] x_min,
        input logic [3:0] x_max,
        input logic [3:0] y_min,
        input logic [3:0] y_max
    );
        logic [3:0] cx;
        logic [3:0] cy;
        cx = cand[3:0];
        cy = cand[7:4];
        return (cx > x_min) && (cx < x_max) && (cy > y_min) && (cy < y_max);
    endfunction

endpackage

// File: rtl/apple_rand_gen_if.sv
// Bundle between the apple placer (master) and the random location generator
// (slave): request/seed controls, playfield bounds and the candidate result.
interface apple_rand_gen_if;

    logic        enable;
    logic        seed_load;
    logic [15:0] seed;
    logic [3:0]  XMAX;
    logic [3:0]  XMIN;
    logic [3:0]  YMAX;
    logic [3:0]  YMIN;
    logic [7:0]  apple_possible;
    logic        possible_valid;
    logic        exhausted;

    modport master (
        output enable,
        output seed_load,
        output seed,
        output XMAX,
        output XMIN,
        output YMAX,
        output YMIN,
        input  apple_possible,
        input  possible_valid,
        input  exhausted
    );

    modport slave (
        input  enable,
        input  seed_load,
        input  seed,
        input  XMAX,
        input  XMIN,
        input  YMAX,
        input  YMIN,
        output apple_possible,
        output possible_valid,
        output exhausted
    );

endinterface

// File: rtl/apple_rand_gen_lfsr16_step.sv
// One step of the 16-bit Galois LFSR: shift right, and fold the tap mask back
// in whenever the bit shifted out was a one. Purely combinational.
module lfsr16_step
    import apple_rand_gen_pkg::*;
(
    input  logic [15:0] lfsr_in,
    output logic [15:0] lfsr_out
);

    // Single shift with feedback; a nonzero input never yields zero.
    always_comb begin
        lfsr_out = lfsr_in >> 1;
        if (lfsr_in[0]) begin
            lfsr_out = (lfsr_in >> 1) ^ LFSR_TAPS;
        end
    end

endmodule

// File: rtl/apple_rand_gen.sv
// Random apple location generator. While the placer holds enable, the LFSR
// steps once per clock and each new low byte is offered as a {y, x} candidate;
// the first candidate strictly inside the playfield is registered and flagged
// valid. If RETRY_MAX candidates in a row are rejected, the fixed fallback
// location is presented with exhausted set, so the search can never hang.
//
// Optional feature: define APPLE_RAND_ENTROPY_EN to add a free-running 16-bit
// counter that is XORed into the LFSR every time a search starts, so the
// sequence depends on when the player asked for an apple. Without it the
// output is fully deterministic from SEED or the loaded seed.
module apple_rand_gen
    import apple_rand_gen_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [7:0]  RETRY_MAX = 8'd255
) (
    input  logic             system_clk,
    input  logic             reset,
    apple_rand_gen_if.slave  bus
);

    apple_state_t state_q;
    apple_state_t state_d;
    logic [15:0]  lfsr_q;
    logic [15:0]  lfsr_d;
    logic [7:0]   apple_q;
    logic [7:0]   apple_d;
    logic         valid_q;
    logic         valid_d;
    logic         exhausted_q;
    logic         exhausted_d;
    logic [7:0]   retry_q;
    logic [7:0]   retry_d;

    logic [15:0]  lfsr_next;
    logic [7:0]   candidate;
    logic         cand_ok;
    logic         retry_last;
    logic [15:0]  seed_value;

`ifdef APPLE_RAND_ENTROPY_EN
    logic [15:0]  entropy_q;
    logic [15:0]  entropy_d;
    logic [15:0]  lfsr_mixed;
`endif

    lfsr16_step u_step (
        .lfsr_in  (lfsr_q),
        .lfsr_out (lfsr_next)
    );

    // Candidate is the low byte of the value the LFSR is about to take, so the
    // registered apple and the new LFSR state land on the same edge.
    always_comb begin
        candidate  = lfsr_next[7:0];
        cand_ok    = in_bounds(candidate, bus.XMIN, bus.XMAX, bus.YMIN, bus.YMAX);
        retry_last = (({1'b0, retry_q} + 9'd1) >= {1'b0, RETRY_MAX});
        seed_value = (bus.seed == 16'h0000) ? SEED : bus.seed;
    end

`ifdef APPLE_RAND_ENTROPY_EN
    // Free-running counter and the mixed LFSR value used when a search starts;
    // a zero mix is replaced by SEED so the LFSR can never lock up.
    always_comb begin
        entropy_d  = entropy_q + 16'd1;
        lfsr_mixed = lfsr_q ^ entropy_q;
        if (lfsr_mixed == 16'h0000) begin
            lfsr_mixed = SEED;
        end
    end
`endif

    // Next-state logic: a seed load overrides everything else; otherwise the
    // FSM decides whether the LFSR steps and what the outputs become.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        apple_d     = apple_q;
        valid_d     = valid_q;
        exhausted_d = exhausted_q;
        retry_d     = retry_q;

        if (bus.seed_load) begin
            lfsr_d      = seed_value;
            state_d     = IDLE;
            exhausted_d = 1'b0;
            retry_d     = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        state_d = SEARCH;
                        valid_d = 1'b0;
`ifdef APPLE_RAND_ENTROPY_EN
                        lfsr_d  = lfsr_mixed;
`endif
                    end
                end
                SEARCH: begin
                    lfsr_d = lfsr_next;
                    if (cand_ok) begin
                        apple_d     = candidate;
                        valid_d     = 1'b1;
                        exhausted_d = 1'b0;
                        retry_d     = 8'd0;
                        state_d     = FOUND;
                    end else if (retry_last) begin
                        apple_d     = DEFAULT_APPLE;
                        valid_d     = 1'b1;
                        exhausted_d = 1'b1;
                        retry_d     = 8'd0;
                        state_d     = FOUND;
                    end else begin
                        retry_d = retry_q + 8'd1;
                    end
                end
                FOUND: begin
                    retry_d = 8'd0;
                    if (bus.enable) begin
                        state_d = SEARCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    retry_d = 8'd0;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            apple_q     <= DEFAULT_APPLE;
            valid_q     <= 1'b0;
            exhausted_q <= 1'b0;
            retry_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            apple_q     <= apple_d;
            valid_q     <= valid_d;
            exhausted_q <= exhausted_d;
            retry_q     <= retry_d;
        end
    end

`ifdef APPLE_RAND_ENTROPY_EN
    // Entropy counter runs regardless of FSM state and restarts from zero on reset.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            entropy_q <= 16'd0;
        end else begin
            entropy_q <= entropy_d;
        end
    end
`endif

    assign bus.apple_possible = apple_q;
    assign bus.possible_valid = valid_q;
    assign bus.exhausted      = exhausted_q;

endmodule

// File: tb/tb_apple_rand_gen.sv
// Self-checking bench for apple_rand_gen. Directed steps in one initial block;
// searches are predicted by a small reference model whose results are queued
// when the request is driven and popped when the DUT reaches FOUND.
module tb_apple_rand_gen;
    import apple_rand_gen_pkg::*;

    logic system_clk = 1'b0;
    logic reset      = 1'b1;

    apple_rand_gen_if bus ();

    apple_rand_gen #(
        .SEED      (16'hACE1),
        .RETRY_MAX (8'd255)
    ) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 system_clk = ~system_clk;

    typedef struct {
        logic [7:0]  apple;
        logic        exh;
        int          edges;
        logic [15:0] lfsr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference LFSR step written independently from the RTL.
    function automatic logic [15:0] model_step(input logic [15:0] v);
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive bounds and enable from IDLE, and queue the predicted search result.
    task automatic applyStimulus(input logic [3:0] xmin, input logic [3:0] xmax,
                                 input logic [3:0] ymin, input logic [3:0] ymax,
                                 input logic [15:0] start);
        exp_t        e;
        logic [15:0] l;
        bit          found;
        bus.XMIN   = xmin;
        bus.XMAX   = xmax;
        bus.YMIN   = ymin;
        bus.YMAX   = ymax;
        bus.enable = 1'b1;
        l       = start;
        found   = 1'b0;
        e.apple = 8'h46;
        e.exh   = 1'b1;
        e.edges = 1 + 255;
        for (int i = 1; i <= 255 && !found; i++) begin
            l = model_step(l);
            if (l[3:0] > xmin && l[3:0] < xmax && l[7:4] > ymin && l[7:4] < ymax) begin
                found   = 1'b1;
                e.apple = l[7:0];
                e.exh   = 1'b0;
                e.edges = 1 + i;
            end
        end
        e.lfsr = l;
        sb.push_back(e);
    endtask

    // Wait (bounded) for FOUND, checking the held apple meanwhile, then score.
    task automatic checkOutput(input string tag, input logic [7:0] held, output logic [7:0] got);
        int   n;
        bit   done;
        exp_t e;
        n    = 0;
        done = 1'b0;
        while (!done && n < 600) begin
            tick();
            n++;
            if (dut.state_q == FOUND) done = 1'b1;
            else check({tag, "_held"}, {24'd0, bus.apple_possible}, {24'd0, held});
        end
        check({tag, "_timeout"}, {31'd0, done}, 32'd1);
        got = bus.apple_possible;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_apple"}, {24'd0, bus.apple_possible}, {24'd0, e.apple});
            check({tag, "_exh"}, {31'd0, bus.exhausted}, {31'd0, e.exh});
            check({tag, "_valid"}, {31'd0, bus.possible_valid}, 32'd1);
            check({tag, "_edges"}, n, e.edges);
            check({tag, "_lfsr"}, {16'd0, dut.lfsr_q}, {16'd0, e.lfsr});
        end
    endtask

    initial begin
        logic [7:0] last_apple;
        bus.enable    = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed      = 16'h0000;
        bus.XMIN      = 4'd0;
        bus.XMAX      = 4'd15;
        bus.YMIN      = 4'd0;
        bus.YMAX      = 4'd11;
        reset         = 1'b1;
        tick();
        reset = 1'b0;

        $display("[TB] reset state");
        check("rst_lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_apple", {24'd0, bus.apple_possible}, 32'h46);
        check("rst_valid", {31'd0, bus.possible_valid}, 32'd0);
        check("rst_exh", {31'd0, bus.exhausted}, 32'd0);

`ifdef APPLE_RAND_ENTROPY_EN
        begin
            logic [7:0] first_a;
            logic [7:0] first_b;
            bit         ok;
            repeat (3) tick();
            bus.enable = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 600 && !ok; i++) begin
                tick();
                if (dut.state_q == FOUND) ok = 1'b1;
            end
            check("ent_a_timeout", {31'd0, ok}, 32'd1);
            first_a    = bus.apple_possible;
            bus.enable = 1'b0;
            reset      = 1'b1;
            tick();
            reset = 1'b0;
            repeat (11) tick();
            bus.enable = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 600 && !ok; i++) begin
                tick();
                if (dut.state_q == FOUND) ok = 1'b1;
            end
            check("ent_b_timeout", {31'd0, ok}, 32'd1);
            first_b    = bus.apple_possible;
            bus.enable = 1'b0;
            check("ent_differ", {31'd0, (first_a != first_b)}, 32'd1);
        end
`else
        $display("[TB] first search from SEED");
        bus.enable = 1'b1;
        tick();
        check("w1_state", 32'(dut.state_q), 32'(SEARCH));
        check("w1_valid", {31'd0, bus.possible_valid}, 32'd0);
        tick();
        check("w2_lfsr", {16'd0, dut.lfsr_q}, 32'h0000E270);
        check("w2_apple", {24'd0, bus.apple_possible}, 32'h46);
        check("w2_valid", {31'd0, bus.possible_valid}, 32'd0);
        tick();
        check("w3_lfsr", {16'd0, dut.lfsr_q}, 32'h00007138);
        check("w3_apple", {24'd0, bus.apple_possible}, 32'h38);
        check("w3_valid", {31'd0, bus.possible_valid}, 32'd1);
        check("w3_state", 32'(dut.state_q), 32'(FOUND));
        bus.enable = 1'b0;

        $display("[TB] hold in IDLE");
        tick();
        check("hold_state", 32'(dut.state_q), 32'(IDLE));
        check("hold_valid", {31'd0, bus.possible_valid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_apple", {24'd0, bus.apple_possible}, 32'h38);
            check("hold_lfsr", {16'd0, dut.lfsr_q}, 32'h00007138);
        end

        $display("[TB] degenerate bounds exhaust");
        applyStimulus(4'd5, 4'd6, 4'd0, 4'd11, 16'h7138);
        checkOutput("exhaust", 8'h38, last_apple);

        $display("[TB] seed load of zero during search");
        tick();
        check("re_search", 32'(dut.state_q), 32'(SEARCH));
        tick();
        tick();
        bus.seed_load = 1'b1;
        bus.seed      = 16'h0000;
        tick();
        bus.seed_load = 1'b0;
        bus.enable    = 1'b0;
        check("sl0_lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
        check("sl0_state", 32'(dut.state_q), 32'(IDLE));
        check("sl0_apple", {24'd0, bus.apple_possible}, 32'h46);
        check("sl0_exh", {31'd0, bus.exhausted}, 32'd0);
        check("sl0_retry", {24'd0, dut.retry_q}, 32'd0);

        $display("[TB] seed load and narrow bounds");
        bus.seed_load = 1'b1;
        bus.seed      = 16'hBEEF;
        tick();
        bus.seed_load = 1'b0;
        check("slb_lfsr", {16'd0, dut.lfsr_q}, 32'h0000BEEF);
        check("slb_state", 32'(dut.state_q), 32'(IDLE));
        applyStimulus(4'd8, 4'd15, 4'd2, 4'd9, 16'hBEEF);
        checkOutput("bounds_b", 8'h46, last_apple);
        bus.enable = 1'b0;
        tick();
        check("b_idle", 32'(dut.state_q), 32'(IDLE));

        $display("[TB] reset during search");
        bus.XMIN   = 4'd5;
        bus.XMAX   = 4'd6;
        bus.enable = 1'b1;
        tick();
        tick();
        tick();
        check("mid_state", 32'(dut.state_q), 32'(SEARCH));
        check("mid_apple", {24'd0, bus.apple_possible}, {24'd0, last_apple});
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        bus.enable = 1'b0;
        check("mr_lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
        check("mr_apple", {24'd0, bus.apple_possible}, 32'h46);
        check("mr_valid", {31'd0, bus.possible_valid}, 32'd0);
        check("mr_state", 32'(dut.state_q), 32'(IDLE));

        $display("[TB] search again after reset");
        applyStimulus(4'd0, 4'd15, 4'd0, 4'd11, 16'hACE1);
        checkOutput("after_rst", 8'h46, last_apple);
        bus.enable = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
